uart_rx_ctrl: RTL and testbench

Sequencing controller for the UART receive datapath. Synchronises the raw RX line, generates the mid-bit sample strobe from a programmable baud divisor, and runs the frame FSM (IDLE, START, DATA, PARITY/CRC, STOP). It drives the datapath's `trigger`, `changed_rx_state` and one-hot phase flags, and consumes the datapath's `sampled_start` and `bit_cnt` back.

---
 rtl/uart_rx_ctrl.sv | 120 ++++++++++++
 tb/tb_uart_rx_ctrl.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_ctrl.sv
// UART receive sequencing controller: RX line synchroniser, mid-bit baud strobe and frame FSM.
// Optional build macro UART_RX_FALSE_START_EN: abort the frame when the start bit reads high at mid-bit.
module uart_rx_ctrl #(
    parameter int unsigned DIV_W     = 16,
    parameter int unsigned DATA_BITS = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             rx_en_i,
    input  logic             rx_i,
    input  logic             crc_en_i,
    input  logic [DIV_W-1:0] baud_div_i,
    input  logic             sampled_start_i,
    input  logic [4:0]       bit_cnt_i,
    output logic             rx_o,
    output logic             trigger_o,
    output logic             changed_rx_state_o,
    output logic             is_rx_idle_o,
    output logic             is_rx_data_o,
    output logic             is_rx_pairity_o,
    output logic             is_rx_crc_o,
    output logic             is_rx_stop_o,
    output logic             busy_o,
    output logic             frame_err_o
);

    localparam int unsigned MIN_DIV  = 4;
    localparam logic [4:0]  LAST_BIT = 5'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_CRC,
        ST_STOP
    } state_e;

    state_e           state_q, state_d;
    logic             rx_meta_q, rx_q;
    logic [DIV_W-1:0] baud_cnt_q, baud_cnt_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic             last_bit;

    // State, synchroniser and baud registers
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rx_meta_q  <= 1'b1;
            rx_q       <= 1'b1;
            state_q    <= ST_IDLE;
            baud_cnt_q <= '0;
            div_q      <= DIV_W'(MIN_DIV);
        end else begin
            rx_meta_q  <= rx_i;
            rx_q       <= rx_meta_q;
            state_q    <= state_d;
            baud_cnt_q <= baud_cnt_d;
            div_q      <= div_d;
        end
    end

    assign rx_o            = rx_q;
    assign is_rx_idle_o    = (state_q == ST_IDLE);
    assign is_rx_data_o    = (state_q == ST_DATA);
    assign is_rx_pairity_o = (state_q == ST_PARITY);
    assign is_rx_crc_o     = (state_q == ST_CRC);
    assign is_rx_stop_o    = (state_q == ST_STOP);
    assign busy_o          = ~is_rx_idle_o;

    // IDLE strobes every cycle so the datapath can hunt for the start edge
    assign trigger_o   = rx_en_i & (is_rx_idle_o | (baud_cnt_q == '0));
    assign last_bit    = (bit_cnt_i == LAST_BIT);
    assign frame_err_o = trigger_o & is_rx_stop_o & ~rx_q;

    always_comb begin
        changed_rx_state_o = 1'b0;
        case (state_q)
            ST_START, ST_PARITY, ST_STOP: changed_rx_state_o = trigger_o;
            ST_DATA, ST_CRC:              changed_rx_state_o = trigger_o & last_bit;
            default:                      changed_rx_state_o = 1'b0;
        endcase
    end

    // Next-state: disable wins over everything, phases advance only on their last sample
    always_comb begin
        state_d    = state_q;
        baud_cnt_d = baud_cnt_q;
        div_d      = div_q;
        if (!rx_en_i) begin
            state_d    = ST_IDLE;
            baud_cnt_d = '0;
        end else if (state_q == ST_IDLE) begin
            if (sampled_start_i) begin
                div_d      = (baud_div_i < DIV_W'(MIN_DIV)) ? DIV_W'(MIN_DIV) : baud_div_i;
                baud_cnt_d = (div_d >> 1) - DIV_W'(1);
                state_d    = ST_START;
            end
        end else begin
            baud_cnt_d = trigger_o ? (div_q - DIV_W'(1)) : (baud_cnt_q - DIV_W'(1));
            if (changed_rx_state_o) begin
                case (state_q)
`ifdef UART_RX_FALSE_START_EN
                    ST_START:  state_d = rx_q ? ST_IDLE : ST_DATA;
`else
                    ST_START:  state_d = ST_DATA;
`endif
                    ST_DATA:   state_d = crc_en_i ? ST_CRC : ST_PARITY;
                    ST_PARITY: state_d = ST_STOP;
                    ST_CRC:    state_d = ST_STOP;
                    ST_STOP:   state_d = ST_IDLE;
                    default:   state_d = ST_IDLE;
                endcase
            end
            if (state_d == ST_IDLE) begin
                baud_cnt_d = '0;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Self-checking bench for uart_rx_ctrl: models the RX datapath, drives serial frames
// and scoreboards every non-idle trigger against expected phase, offset and flags.
module tb_uart_rx_ctrl;

    localparam int unsigned DIV_W     = 16;
    localparam int unsigned DATA_BITS = 8;
    localparam int          NB        = 8;
    localparam int          NONE      = 1000000;

    localparam logic [4:0] PH_START = 5'b00000;
    localparam logic [4:0] PH_DATA  = 5'b01000;
    localparam logic [4:0] PH_PAR   = 5'b00100;
    localparam logic [4:0] PH_CRC   = 5'b00010;
    localparam logic [4:0] PH_STOP  = 5'b00001;

    typedef struct {
        logic [4:0] ph;
        logic       chg;
        logic       ferr;
        int         ofs;
    } exp_t;

    logic             clk_i;
    logic             rst_i;
    logic             rx_en_i;
    logic             rx_i;
    logic             crc_en_i;
    logic [DIV_W-1:0] baud_div_i;
    logic             sampled_start_i;
    logic [4:0]       bit_cnt_i;
    logic             rx_o, trigger_o, changed_rx_state_o;
    logic             is_rx_idle_o, is_rx_data_o, is_rx_pairity_o, is_rx_crc_o, is_rx_stop_o;
    logic             busy_o, frame_err_o;
    logic [4:0]       ph_w;
    logic [7:0]       shreg_q;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    uart_rx_ctrl #(.DIV_W(DIV_W), .DATA_BITS(DATA_BITS)) dut (
        .clk_i              (clk_i),
        .rst_i              (rst_i),
        .rx_en_i            (rx_en_i),
        .rx_i               (rx_i),
        .crc_en_i           (crc_en_i),
        .baud_div_i         (baud_div_i),
        .sampled_start_i    (sampled_start_i),
        .bit_cnt_i          (bit_cnt_i),
        .rx_o               (rx_o),
        .trigger_o          (trigger_o),
        .changed_rx_state_o (changed_rx_state_o),
        .is_rx_idle_o       (is_rx_idle_o),
        .is_rx_data_o       (is_rx_data_o),
        .is_rx_pairity_o    (is_rx_pairity_o),
        .is_rx_crc_o        (is_rx_crc_o),
        .is_rx_stop_o       (is_rx_stop_o),
        .busy_o             (busy_o),
        .frame_err_o        (frame_err_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    assign ph_w            = {is_rx_idle_o, is_rx_data_o, is_rx_pairity_o, is_rx_crc_o, is_rx_stop_o};
    assign sampled_start_i = is_rx_idle_o & ~rx_o & trigger_o;

    // Datapath model: bit counter and LSB-first data shifter
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            bit_cnt_i <= 5'd0;
            shreg_q   <= 8'h00;
        end else if (trigger_o) begin
            if (changed_rx_state_o)
                bit_cnt_i <= 5'd0;
            else if (is_rx_data_o || is_rx_crc_o)
                bit_cnt_i <= bit_cnt_i + 5'd1;
            if (is_rx_data_o)
                shreg_q <= {rx_o, shreg_q[7:1]};
        end
    end

    function automatic logic wave(input int k, input logic [7:0] data, input bit crc,
                                  input logic [7:0] crcb, input int d, input bit stop_ok,
                                  input int glitch);
        int b;
        if (glitch > 0) return (k < glitch) ? 1'b0 : 1'b1;
        b = k / d;
        if (b == 0) return 1'b0;
        if (b <= NB) return data[b-1];
        if (crc && b <= 2*NB) return crcb[b-NB-1];
        if (!crc && b == NB+1) return ~^data;
        if ((crc && b == 2*NB+1) || (!crc && b == NB+2))
            return stop_ok ? 1'b1 : ((k % d) <= d/2 ? 1'b0 : 1'b1);
        return 1'b1;
    endfunction

    task automatic push_frame(input int div, input bit crc, input bit stop_ok, input int n);
        int   d;
        int   total;
        exp_t e;
        d     = (div < 4) ? 4 : div;
        total = crc ? 2*NB + 2 : NB + 3;
        for (int i = 0; i < total && i < n; i++) begin
            e.chg  = 1'b1;
            e.ferr = 1'b0;
            e.ofs  = d/2 + d*i;
            if (i == 0) e.ph = PH_START;
            else if (i <= NB) begin
                e.ph  = PH_DATA;
                e.chg = (i == NB);
            end else if (i == total-1) begin
                e.ph   = PH_STOP;
                e.ferr = !stop_ok;
            end else if (crc) begin
                e.ph  = PH_CRC;
                e.chg = (i == 2*NB);
            end else e.ph = PH_PAR;
            exp_q.push_back(e);
        end
    endtask

    // Drives one serial waveform and pops the scoreboard on every non-idle trigger
    task automatic run_frame(input logic [7:0] data, input bit crc, input logic [7:0] crcb,
                             input int d, input bit stop_ok, input int glitch,
                             input int dis_ofs, input int chg_ofs, input int budget);
        int   det;
        bit   prev_ferr;
        exp_t e;
        det       = -1;
        prev_ferr = 1'b0;
        crc_en_i  = crc;
        for (int c = 0; c < budget; c++) begin
            @(posedge clk_i); #1;
            rx_i = wave(c, data, crc, crcb, d, stop_ok, glitch);
            if (det >= 0 && c - det == chg_ofs) baud_div_i = 16'd32;
            if (det >= 0 && c - det == dis_ofs) rx_en_i = 1'b0;
            @(negedge clk_i);
            if (det < 0 && sampled_start_i) det = c;
            if (prev_ferr) begin
                checks++;
                if (is_rx_idle_o !== 1'b1) begin
                    errors++;
                    $display("FAIL idle_after_ferr: is_rx_idle_o=%b expected 1", is_rx_idle_o);
                end
            end
            prev_ferr = frame_err_o;
            if (trigger_o && !is_rx_idle_o) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL extra_trigger: offset %0d phase=%b, expected no trigger", c - det, ph_w);
                end else begin
                    e = exp_q.pop_front();
                    if (ph_w !== e.ph || changed_rx_state_o !== e.chg || frame_err_o !== e.ferr || c - det != e.ofs) begin
                        errors++;
                        $display("FAIL trigger: got phase=%b chg=%b ferr=%b ofs=%0d, expected phase=%b chg=%b ferr=%b ofs=%0d",
                                 ph_w, changed_rx_state_o, frame_err_o, c - det, e.ph, e.chg, e.ferr, e.ofs);
                    end
                end
            end else begin
                checks++;
                if (changed_rx_state_o !== 1'b0 || frame_err_o !== 1'b0) begin
                    errors++;
                    $display("FAIL quiet_cycle: chg=%b ferr=%b expected 0 0", changed_rx_state_o, frame_err_o);
                end
            end
            if (det >= 0 && c - det == dis_ofs) begin
                checks++;
                if (trigger_o !== 1'b0) begin
                    errors++;
                    $display("FAIL disable_trigger: trigger_o=%b expected 0", trigger_o);
                end
            end
            if (det >= 0 && c - det == dis_ofs + 1) begin
                checks++;
                if (is_rx_idle_o !== 1'b1 || busy_o !== 1'b0 || trigger_o !== 1'b0) begin
                    errors++;
                    $display("FAIL disable_idle: idle=%b busy=%b trig=%b expected 1 0 0", is_rx_idle_o, busy_o, trigger_o);
                end
            end
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL missing_triggers: %0d expected triggers never seen", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_reset;
        rst_i = 1'b1; rx_en_i = 1'b1; rx_i = 1'b1; crc_en_i = 1'b0; baud_div_i = 16'd16;
        #12;
        checks++;
        if (ph_w !== 5'b10000 || rx_o !== 1'b1 || busy_o !== 1'b0 || frame_err_o !== 1'b0 ||
            trigger_o !== 1'b1 || changed_rx_state_o !== 1'b0) begin
            errors++;
            $display("FAIL reset: phase=%b rx=%b busy=%b ferr=%b trig=%b chg=%b expected 10000 1 0 0 1 0",
                     ph_w, rx_o, busy_o, frame_err_o, trigger_o, changed_rx_state_o);
        end
        @(posedge clk_i); #1;
        rst_i = 1'b0;
        repeat (3) @(posedge clk_i);
    endtask

    task automatic test_parity_frame;
        baud_div_i = 16'd16;
        push_frame(16, 1'b0, 1'b1, NONE);
        run_frame(8'hA5, 1'b0, 8'h00, 16, 1'b1, 0, NONE, NONE, 16*11 + 40);
        checks++;
        if (shreg_q !== 8'hA5 || is_rx_idle_o !== 1'b1) begin
            errors++;
            $display("FAIL parity_data: data=%h idle=%b expected a5 1", shreg_q, is_rx_idle_o);
        end
    endtask

    task automatic test_crc_frame;
        baud_div_i = 16'd10;
        push_frame(10, 1'b1, 1'b1, NONE);
        run_frame(8'h5A, 1'b1, 8'hC3, 10, 1'b1, 0, NONE, NONE, 10*18 + 30);
        checks++;
        if (shreg_q !== 8'h5A || is_rx_idle_o !== 1'b1) begin
            errors++;
            $display("FAIL crc_data: data=%h idle=%b expected 5a 1", shreg_q, is_rx_idle_o);
        end
    endtask

    task automatic test_frame_error;
        baud_div_i = 16'd16;
        push_frame(16, 1'b0, 1'b0, NONE);
        run_frame(8'h81, 1'b0, 8'h00, 16, 1'b0, 0, NONE, NONE, 16*11 + 40);
        checks++;
        if (shreg_q !== 8'h81 || is_rx_idle_o !== 1'b1) begin
            errors++;
            $display("FAIL ferr_data: data=%h idle=%b expected 81 1", shreg_q, is_rx_idle_o);
        end
    endtask

    task automatic test_disable;
        baud_div_i = 16'd16;
        push_frame(16, 1'b0, 1'b1, 4);
        run_frame(8'hF0, 1'b0, 8'h00, 16, 1'b1, 0, 8 + 4*16 - 2, NONE, 16*11 + 40);
        rx_en_i = 1'b1;
        repeat (5) @(posedge clk_i);
        push_frame(16, 1'b0, 1'b1, NONE);
        run_frame(8'h3C, 1'b0, 8'h00, 16, 1'b1, 0, NONE, NONE, 16*11 + 40);
        checks++;
        if (shreg_q !== 8'h3C || is_rx_idle_o !== 1'b1) begin
            errors++;
            $display("FAIL reenable_data: data=%h idle=%b expected 3c 1", shreg_q, is_rx_idle_o);
        end
    endtask

    task automatic test_false_start;
        baud_div_i = 16'd16;
`ifdef UART_RX_FALSE_START_EN
        push_frame(16, 1'b0, 1'b1, 1);
`else
        push_frame(16, 1'b0, 1'b1, NONE);
`endif
        run_frame(8'hFF, 1'b0, 8'h00, 16, 1'b1, 4, NONE, NONE, 16*11 + 40);
        checks++;
        if (is_rx_idle_o !== 1'b1) begin
            errors++;
            $display("FAIL false_start_idle: idle=%b expected 1", is_rx_idle_o);
        end
    endtask

    task automatic test_divisor;
        baud_div_i = 16'd2;
        push_frame(2, 1'b0, 1'b1, NONE);
        run_frame(8'h96, 1'b0, 8'h00, 4, 1'b1, 0, NONE, NONE, 4*11 + 16);
        checks++;
        if (shreg_q !== 8'h96) begin
            errors++;
            $display("FAIL clamp_data: data=%h expected 96", shreg_q);
        end
        baud_div_i = 16'd16;
        push_frame(16, 1'b0, 1'b1, NONE);
        run_frame(8'h69, 1'b0, 8'h00, 16, 1'b1, 0, NONE, 30, 16*11 + 40);
        checks++;
        if (shreg_q !== 8'h69) begin
            errors++;
            $display("FAIL latch_data: data=%h expected 69", shreg_q);
        end
        baud_div_i = 16'd16;
    endtask

    task automatic test_reset_mid_frame;
        @(posedge clk_i); #1;
        rx_i = 1'b0;
        repeat (20) @(posedge clk_i);
        #1;
        checks++;
        if (busy_o !== 1'b1) begin
            errors++;
            $display("FAIL midreset_busy: busy=%b expected 1", busy_o);
        end
        rst_i = 1'b1;
        #1;
        checks++;
        if (ph_w !== 5'b10000 || busy_o !== 1'b0 || rx_o !== 1'b1 || frame_err_o !== 1'b0 ||
            changed_rx_state_o !== 1'b0) begin
            errors++;
            $display("FAIL midreset: phase=%b busy=%b rx=%b ferr=%b chg=%b expected 10000 0 1 0 0",
                     ph_w, busy_o, rx_o, frame_err_o, changed_rx_state_o);
        end
        rx_i = 1'b1;
        @(posedge clk_i); #1;
        rst_i = 1'b0;
        repeat (4) @(posedge clk_i);
        #1;
        checks++;
        if (is_rx_idle_o !== 1'b1) begin
            errors++;
            $display("FAIL post_reset_idle: idle=%b expected 1", is_rx_idle_o);
        end
    endtask

    initial begin
        test_reset();
        test_parity_frame();
        test_crc_frame();
        test_frame_error();
        test_disable();
        test_false_start();
        test_divisor();
        test_reset_mid_frame();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
